// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS pipeline: datapath widths, control-bundle
// bit positions and the bubble value of the control bundle.
package mips_pkg;

   localparam int DW = 32;
   localparam int AW = 5;
   localparam int CW = 8;

   localparam int CTRL_REG_WRITE  = 0;
   localparam int CTRL_MEM_READ   = 1;
   localparam int CTRL_MEM_WRITE  = 2;
   localparam int CTRL_MEM_TO_REG = 3;
   localparam int CTRL_ALU_SRC    = 4;
   localparam int CTRL_ALU_OP_LSB = 5;

   localparam logic [CW-1:0] CTRL_BUBBLE = '0;

   localparam int STALL_CNT_W = 16;

endpackage

// File: rtl/id_ex_stage_hazard_detect.sv
// Load-use compare: an in-flight load in EX whose destination is read by the
// instruction in ID. Both sources are checked regardless of instruction type.
module hazard_detect #(
   parameter int AW = 5
) (
   input  logic          ex_valid,
   input  logic          ex_mem_read,
   input  logic [AW-1:0] ex_dst,
   input  logic          id_valid,
   input  logic [AW-1:0] id_rs,
   input  logic [AW-1:0] id_rt,
   output logic          hz
);

   always_comb begin
      hz = ex_valid && ex_mem_read && (ex_dst != '0) && id_valid &&
           ((ex_dst == id_rs) || (ex_dst == id_rt));
   end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with same-edge WB bypass, load-use stall/bubble,
// branch flush and a saturating stall-cycle counter.
module id_ex_stage #(
   parameter int DW = mips_pkg::DW,
   parameter int AW = mips_pkg::AW,
   parameter int CW = mips_pkg::CW
) (
   input  logic          clk,
   input  logic          rstb,
   input  logic          id_valid,
   input  logic [AW-1:0] id_rs,
   input  logic [AW-1:0] id_rt,
   input  logic [AW-1:0] id_dst,
   input  logic [DW-1:0] id_rd_data1,
   input  logic [DW-1:0] id_rd_data2,
   input  logic [DW-1:0] id_imm,
   input  logic [CW-1:0] id_ctrl,
   input  logic          wb_wr_e,
   input  logic [AW-1:0] wb_wr_addr,
   input  logic [DW-1:0] wb_wr_data,
   input  logic          flush,
   input  logic          stall_cnt_clr,
   output logic          stall,
   output logic          ex_valid,
   output logic [AW-1:0] ex_rs,
   output logic [AW-1:0] ex_rt,
   output logic [AW-1:0] ex_dst,
   output logic [DW-1:0] ex_op_a,
   output logic [DW-1:0] ex_op_b,
   output logic [DW-1:0] ex_imm,
   output logic [CW-1:0] ex_ctrl,
   output logic [15:0]   stall_cnt
);

   import mips_pkg::*;

   logic          hz;
   logic          ex_valid_q, ex_valid_d;
   logic [AW-1:0] ex_rs_q, ex_rs_d;
   logic [AW-1:0] ex_rt_q, ex_rt_d;
   logic [AW-1:0] ex_dst_q, ex_dst_d;
   logic [DW-1:0] ex_op_a_q, ex_op_a_d;
   logic [DW-1:0] ex_op_b_q, ex_op_b_d;
   logic [DW-1:0] ex_imm_q, ex_imm_d;
   logic [CW-1:0] ex_ctrl_q, ex_ctrl_d;
   logic [STALL_CNT_W-1:0] stall_cnt_q, stall_cnt_d;
   logic [DW-1:0] op_a_byp, op_b_byp;

   hazard_detect #(.AW(AW)) u_hazard_detect (
      .ex_valid    (ex_valid_q),
      .ex_mem_read (ex_ctrl_q[CTRL_MEM_READ]),
      .ex_dst      (ex_dst_q),
      .id_valid    (id_valid),
      .id_rs       (id_rs),
      .id_rt       (id_rt),
      .hz          (hz)
   );

   assign stall = hz && !flush;

   // The regfile write lands on the same edge as this capture, so the read
   // data it presents is stale for a register being written back right now.
   always_comb begin
      op_a_byp = id_rd_data1;
      op_b_byp = id_rd_data2;
      if (wb_wr_e && (wb_wr_addr != '0) && (wb_wr_addr == id_rs)) begin
         op_a_byp = wb_wr_data;
      end
      if (wb_wr_e && (wb_wr_addr != '0) && (wb_wr_addr == id_rt)) begin
         op_b_byp = wb_wr_data;
      end
   end

   always_comb begin
      ex_valid_d = 1'b0;
      ex_rs_d    = '0;
      ex_rt_d    = '0;
      ex_dst_d   = '0;
      ex_op_a_d  = '0;
      ex_op_b_d  = '0;
      ex_imm_d   = '0;
      ex_ctrl_d  = CTRL_BUBBLE;
      if (!flush && !stall) begin
         ex_valid_d = id_valid;
         ex_rs_d    = id_rs;
         ex_rt_d    = id_rt;
         ex_dst_d   = id_dst;
         ex_op_a_d  = op_a_byp;
         ex_op_b_d  = op_b_byp;
         ex_imm_d   = id_imm;
         ex_ctrl_d  = id_valid ? id_ctrl : CTRL_BUBBLE;
      end
   end

   always_comb begin
      stall_cnt_d = stall_cnt_q;
      if (stall_cnt_clr) begin
         stall_cnt_d = '0;
      end else if (stall && (stall_cnt_q != '1)) begin
         stall_cnt_d = stall_cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rstb) begin
      if (!rstb) begin
         ex_valid_q  <= 1'b0;
         ex_rs_q     <= '0;
         ex_rt_q     <= '0;
         ex_dst_q    <= '0;
         ex_op_a_q   <= '0;
         ex_op_b_q   <= '0;
         ex_imm_q    <= '0;
         ex_ctrl_q   <= CTRL_BUBBLE;
         stall_cnt_q <= '0;
      end else begin
         ex_valid_q  <= ex_valid_d;
         ex_rs_q     <= ex_rs_d;
         ex_rt_q     <= ex_rt_d;
         ex_dst_q    <= ex_dst_d;
         ex_op_a_q   <= ex_op_a_d;
         ex_op_b_q   <= ex_op_b_d;
         ex_imm_q    <= ex_imm_d;
         ex_ctrl_q   <= ex_ctrl_d;
         stall_cnt_q <= stall_cnt_d;
      end
   end

   assign ex_valid  = ex_valid_q;
   assign ex_rs     = ex_rs_q;
   assign ex_rt     = ex_rt_q;
   assign ex_dst    = ex_dst_q;
   assign ex_op_a   = ex_op_a_q;
   assign ex_op_b   = ex_op_b_q;
   assign ex_imm    = ex_imm_q;
   assign ex_ctrl   = ex_ctrl_q;
   assign stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_id_ex_stage.sv
// Self-checking bench for id_ex_stage: directed scenarios followed by random
// traffic, all checked against an architectural register-file/pipeline model.
module tb_id_ex_stage;

   logic        clk = 1'b0;
   logic        rstb;
   logic        id_valid;
   logic [4:0]  id_rs, id_rt, id_dst;
   logic [31:0] id_rd_data1, id_rd_data2, id_imm;
   logic [7:0]  id_ctrl;
   logic        wb_wr_e;
   logic [4:0]  wb_wr_addr;
   logic [31:0] wb_wr_data;
   logic        flush, stall_cnt_clr;
   logic        stall, ex_valid;
   logic [4:0]  ex_rs, ex_rt, ex_dst;
   logic [31:0] ex_op_a, ex_op_b, ex_imm;
   logic [7:0]  ex_ctrl;
   logic [15:0] stall_cnt;

   id_ex_stage dut (
      .clk(clk), .rstb(rstb), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
      .id_dst(id_dst), .id_rd_data1(id_rd_data1), .id_rd_data2(id_rd_data2),
      .id_imm(id_imm), .id_ctrl(id_ctrl), .wb_wr_e(wb_wr_e), .wb_wr_addr(wb_wr_addr),
      .wb_wr_data(wb_wr_data), .flush(flush), .stall_cnt_clr(stall_cnt_clr),
      .stall(stall), .ex_valid(ex_valid), .ex_rs(ex_rs), .ex_rt(ex_rt), .ex_dst(ex_dst),
      .ex_op_a(ex_op_a), .ex_op_b(ex_op_b), .ex_imm(ex_imm), .ex_ctrl(ex_ctrl),
      .stall_cnt(stall_cnt)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int failures = 0;

   // Architectural register file and the expected EX-stage contents.
   logic [31:0] rf [32];
   logic        m_valid;
   logic [4:0]  m_rs, m_rt, m_dst;
   logic [31:0] m_a, m_b, m_imm;
   logic [7:0]  m_ctrl;
   logic [15:0] m_cnt;
   logic        last_stall;

   localparam logic [7:0] LW  = 8'h0B;
   localparam logic [7:0] ADD = 8'h41;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_valid = 0; m_rs = 0; m_rt = 0; m_dst = 0;
      m_a = 0; m_b = 0; m_imm = 0; m_ctrl = 0; m_cnt = 0;
   endtask

   task automatic check_outputs(input string ph);
      chk({ph, ".ex_valid"}, {31'b0, ex_valid}, {31'b0, m_valid});
      chk({ph, ".ex_ctrl"}, {24'b0, ex_ctrl}, {24'b0, m_ctrl});
      chk({ph, ".ex_rs"}, {27'b0, ex_rs}, {27'b0, m_rs});
      chk({ph, ".ex_rt"}, {27'b0, ex_rt}, {27'b0, m_rt});
      chk({ph, ".ex_dst"}, {27'b0, ex_dst}, {27'b0, m_dst});
      chk({ph, ".ex_op_a"}, ex_op_a, m_a);
      chk({ph, ".ex_op_b"}, ex_op_b, m_b);
      chk({ph, ".ex_imm"}, ex_imm, m_imm);
      chk({ph, ".stall_cnt"}, {16'b0, stall_cnt}, {16'b0, m_cnt});
   endtask

   // One cycle: drive ID/WB at the negedge, check the combinational stall,
   // let the edge happen, then compare the EX registers with the model.
   task automatic step(input string ph, input logic v, input logic [4:0] rs, input logic [4:0] rt,
                       input logic [4:0] dst, input logic [31:0] imm, input logic [7:0] ctrl,
                       input logic we, input logic [4:0] wa, input logic [31:0] wd,
                       input logic fl, input logic clr);
      logic exp_stall, load_use;
      id_valid = v; id_rs = rs; id_rt = rt; id_dst = dst; id_imm = imm; id_ctrl = ctrl;
      id_rd_data1 = rf[rs]; id_rd_data2 = rf[rt];
      wb_wr_e = we; wb_wr_addr = wa; wb_wr_data = wd; flush = fl; stall_cnt_clr = clr;
      #1;
      load_use = m_valid && m_ctrl[1] && (m_dst != 0) && v && ((m_dst == rs) || (m_dst == rt));
      exp_stall = load_use && !fl;
      chk({ph, ".stall"}, {31'b0, stall}, {31'b0, exp_stall});
      last_stall = exp_stall;
      if (we && wa != 0) rf[wa] = wd;
      @(posedge clk);
      if (clr) m_cnt = 0;
      else if (exp_stall && m_cnt != 16'hFFFF) m_cnt = m_cnt + 1;
      if (fl || exp_stall) begin
         m_valid = 0; m_rs = 0; m_rt = 0; m_dst = 0; m_a = 0; m_b = 0; m_imm = 0; m_ctrl = 0;
      end else begin
         m_valid = v; m_rs = rs; m_rt = rt; m_dst = dst; m_imm = imm;
         m_ctrl = v ? ctrl : 8'h00;
         m_a = rf[rs]; m_b = rf[rt];   // value the instruction should see after WB
      end
      @(negedge clk);
      check_outputs(ph);
   endtask

   task automatic load_use_pair(input string ph, input logic clr);
      step({ph, ".lw"}, 1, 5'd1, 5'd2, 5'd8, 32'h10, LW, 0, 0, 0, 0, 0);
      step({ph, ".add"}, 1, 5'd8, 5'd2, 5'd3, 32'h0, ADD, 0, 0, 0, 0, clr);
   endtask

   logic        h_v;
   logic [4:0]  h_rs, h_rt, h_dst;
   logic [31:0] h_imm;
   logic [7:0]  h_ctrl;

   initial begin
      for (int i = 0; i < 32; i++) rf[i] = (i == 0) ? 32'h0 : $urandom;
      model_reset();
      last_stall = 0;
      rstb = 0; id_valid = 0; id_rs = 0; id_rt = 0; id_dst = 0; id_rd_data1 = 0;
      id_rd_data2 = 0; id_imm = 0; id_ctrl = 0; wb_wr_e = 0; wb_wr_addr = 0;
      wb_wr_data = 0; flush = 0; stall_cnt_clr = 0;
      repeat (3) @(negedge clk);
      check_outputs("reset");
      chk("reset.stall", {31'b0, stall}, 32'h0);
      rstb = 1;

      // Load-use: one stall, a bubble, then the dependent add is captured.
      step("lu.lw", 1, 5'd1, 5'd2, 5'd8, 32'h4, LW, 0, 0, 0, 0, 0);
      chk("lu.ex_dst", {27'b0, ex_dst}, 32'd8);
      step("lu.add1", 1, 5'd8, 5'd2, 5'd3, 32'h0, ADD, 0, 0, 0, 0, 0);
      chk("lu.bubble", {31'b0, ex_valid}, 32'h0);
      step("lu.add2", 1, 5'd8, 5'd2, 5'd3, 32'h0, ADD, 0, 0, 0, 0, 0);
      chk("lu.cnt", {16'b0, stall_cnt}, 32'd1);

      // $0 is never a hazard and never bypassed.
      step("z.lw", 1, 5'd1, 5'd2, 5'd0, 32'h0, LW, 0, 0, 0, 0, 0);
      step("z.use", 1, 5'd0, 5'd0, 5'd4, 32'h0, ADD, 1, 5'd0, 32'hDEAD, 0, 0);
      chk("z.op_a", ex_op_a, 32'h0);

      // WB bypass into op_b while the regfile still returns the old value.
      rf[9] = 32'h0;
      step("byp", 1, 5'd3, 5'd9, 5'd5, 32'h7, ADD, 1, 5'd9, 32'h1234_5678, 0, 0);
      chk("byp.op_b", ex_op_b, 32'h1234_5678);

      // Flush beats a load-use hazard.
      step("fl.lw", 1, 5'd1, 5'd2, 5'd8, 32'h0, LW, 0, 0, 0, 0, 0);
      step("fl.add", 1, 5'd8, 5'd8, 5'd3, 32'h0, ADD, 0, 0, 0, 1, 0);
      chk("fl.cnt", {16'b0, stall_cnt}, 32'd1);

      // Reset mid-stream with a load in EX and stall_cnt at 5.
      for (int i = 0; i < 4; i++) load_use_pair("pre", 0);
      step("mid.lw", 1, 5'd1, 5'd2, 5'd8, 32'h0, LW, 0, 0, 0, 0, 0);
      chk("mid.cnt5", {16'b0, stall_cnt}, 32'd5);
      id_valid = 1; id_rs = 5'd8; id_rt = 5'd8;
      #2 rstb = 0;
      #1 model_reset();
      check_outputs("rst_mid");
      chk("rst_mid.stall", {31'b0, stall}, 32'h0);
      @(negedge clk);
      rstb = 1;
      step("post_rst", 1, 5'd6, 5'd7, 5'd10, 32'hCAFE, 8'hA5, 0, 0, 0, 0, 0);

      // Saturation: preload near the top, then keep stalling.
      force dut.stall_cnt_q = 16'hFFFC;
      #1 release dut.stall_cnt_q;
      m_cnt = 16'hFFFC;
      for (int i = 0; i < 6; i++) load_use_pair("sat", 0);
      chk("sat.cnt", {16'b0, stall_cnt}, 32'hFFFF);
      load_use_pair("clr", 1);
      chk("clr.cnt", {16'b0, stall_cnt}, 32'h0);

      // Random traffic; a stalled ID instruction is presented again.
      h_v = 0; h_rs = 0; h_rt = 0; h_dst = 0; h_imm = 0; h_ctrl = 0;
      for (int i = 0; i < 3000; i++) begin
         if (!last_stall) begin
            h_v = ($urandom_range(0, 9) != 0);
            h_rs = 5'($urandom_range(0, 3));
            h_rt = 5'($urandom_range(0, 3));
            h_dst = 5'($urandom_range(0, 3));
            h_imm = $urandom;
            h_ctrl = 8'($urandom);
         end
         step("rnd", h_v, h_rs, h_rt, h_dst, h_imm, h_ctrl, 1'($urandom),
              5'($urandom_range(0, 3)), $urandom, ($urandom_range(0, 9) == 0),
              ($urandom_range(0, 49) == 0));
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL timeout observed=running expected=finished");
      $fatal(1, "timeout");
   end

endmodule

// File: doc/id_ex_stage.md
# id_ex_stage

ID/EX pipeline stage of the 5-stage MIPS core. Captures the register-file read data, immediate and decoded control for one instruction per cycle and presents them to EX one cycle later. It bypasses a same-cycle write-back into the captured operands, detects load-use hazards (stalling IF/ID and inserting a bubble), and applies branch flushes. It also keeps a saturating stall-cycle counter for performance reporting.

## Interface
Parameters:
- DW, 32, datapath width
- AW, 5, register address width
- CW, 8, control bundle width

Ports:
- clk  in  1  clock
- rstb  in  1  reset, asynchronous, active-low
- id_valid  in  1  ID holds a real instruction
- id_rs  in  AW  source register 1 (drives regfile rd_addr1)
- id_rt  in  AW  source register 2 (drives regfile rd_addr2)
- id_dst  in  AW  destination register
- id_rd_data1  in  DW  regfile rd_data1
- id_rd_data2  in  DW  regfile rd_data2
- id_imm  in  DW  sign/zero-extended immediate
- id_ctrl  in  CW  control bits: [0] reg_write, [1] mem_read, [2] mem_write, [3] mem_to_reg, [4] alu_src, [7:5] alu_op
- wb_wr_e  in  1  WB write enable (same net as regfile wr_e)
- wb_wr_addr  in  AW  WB write address
- wb_wr_data  in  DW  WB write data
- flush  in  1  branch taken in EX; kill the instruction in ID
- stall_cnt_clr  in  1  synchronous clear of stall_cnt
- stall  out  1  hold PC and IF/ID this cycle (combinational)
- ex_valid  out  1  EX holds a real instruction
- ex_rs, ex_rt, ex_dst  out  AW  registered register numbers, for forwarding
- ex_op_a, ex_op_b  out  DW  registered operands
- ex_imm  out  DW  registered immediate
- ex_ctrl  out  CW  registered control; all-zero for a bubble
- stall_cnt  out  16  stall cycles seen, saturating

## Operation
- Load-use detection (hz):
  - Condition: ex_valid & ex_ctrl[1] & ex_dst!=0 & id_valid & (ex_dst==id_rs | ex_dst==id_rt).
  - Both sources are compared without regard to instruction type. The resulting conservative stalls are intended.
- stall = hz & !flush.
- WB bypass: if wb_wr_e & wb_wr_addr!=0 & wb_wr_addr==id_rs, the captured op_a is wb_wr_data; otherwise it is id_rd_data1. op_b uses id_rt and id_rd_data2 in the same way.
  - This covers the case where the regfile write lands on the same edge as the capture.
  - Register 0 is never bypassed.
- Register update each posedge, in priority order:
  1. flush: bubble. ex_valid=0, ex_ctrl=0, ex_op_a/ex_op_b/ex_imm=0, ex_rs/ex_rt/ex_dst=0.
  2. stall: bubble, same values as flush. IF/ID holds, so the same ID instruction is presented again next cycle.
  3. otherwise: capture ID. ex_valid=id_valid; ex_ctrl=id_valid ? id_ctrl : 0; remaining fields are captured as-is.
- stall_cnt:
  - stall_cnt_clr: set to 0. Clear has priority over increment.
  - else if stall and stall_cnt!=16'hFFFF: increment.
  - Holds at 16'hFFFF.
- Flush and hz in the same cycle: flush wins, stall=0, bubble is inserted, and the counter does not increment.

## Timing
- Latency: ID→EX is 1 cycle. stall is combinational from current EX registers and ID inputs, with no registered delay.
- A load-use stall lasts exactly 1 cycle. The bubble clears ex_valid, which drops hz on the next cycle.
- Reset (async, any cycle, including mid-stall):
  - All ex_* outputs are 0 and stall_cnt is 0.
  - stall is therefore 0 immediately.
  - The first capture happens on the first posedge after rstb rises.
- Back-to-back loads with no dependency: no stall, full throughput.
- The bypass path is combinational from wb_* into the D inputs only. No output depends combinationally on wb_*.

## Structure
- Shared package mips_pkg:
  - Control-bit index constants: CTRL_REG_WRITE=0, CTRL_MEM_READ=1, CTRL_MEM_WRITE=2, CTRL_MEM_TO_REG=3, CTRL_ALU_SRC=4, CTRL_ALU_OP_LSB=5.
  - Widths DW/AW/CW.
  - Bubble constant (all-zero ctrl).
- One sub-module, hazard_detect: the combinational load-use compare, producing hz. The forwarding unit in EX reuses it.
- Everything else lives flat in id_ex_stage: the bypass muxes, pipeline registers and counter.

## Test plan
- Reset mid-stream: assert rstb=0 while ex_valid=1 and stall_cnt=5 → all outputs 0 at once. The first post-reset capture reflects id_* values.
- Load-use: EX holds lw, ex_dst=8. ID presents add with rs=8 →
  - stall=1 for one cycle, then EX shows a bubble (ex_valid=0, ex_ctrl=0).
  - Next cycle the add is captured and stall=0.
  - stall_cnt increments by 1.
- $0 exemption: EX lw with ex_dst=0 and ID rs=0 → no stall. WB writes addr 0 with data 0xDEAD while ID reads rs=0 → ex_op_a=0.
- WB bypass: wb_wr_e=1, wb_wr_addr=9, wb_wr_data=0x1234_5678, id_rt=9, id_rd_data2=0x0 → ex_op_b=0x1234_5678 next cycle.
- Flush vs stall: load-use condition true and flush=1 in the same cycle → stall=0, bubble captured, stall_cnt unchanged.
- Counter:
  - Force 65535 stall cycles → stall_cnt=0xFFFF and it stays there on further stalls.
  - stall_cnt_clr together with stall → 0.
